bpsk_demod: RTL and testbench
=============================

BPSK_DEMOD -- requirements
Module: bpsk_demod

Interface
REQ-001 SHALL have parameter SAMPLES_PER_SYM, default 256: samples integrated per symbol, range 2..256.
REQ-002 SHALL have parameter ACC_W, default 40: signed accumulator width.
REQ-003 SHALL have port clk_sig  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_sig  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have port sample_sig  input  16: received baseband sample, signed two's complement.
REQ-006 SHALL have port sample_valid  input  1: sample_sig and carrier_sig qualified this cycle.
REQ-007 SHALL have port carrier_sig  input  16: local reference carrier from the carrier generator, signed two's complement.
REQ-008 SHALL have port sym_start  input  1: marks the qualified sample as the first of a symbol.
REQ-009 SHALL have port bit_out  output  1: decided bit, held until the next decision.
REQ-010 SHALL have port bit_valid  output  1: one-cycle strobe qualifying bit_out.
REQ-011 SHALL have port locked  output  1: high once one full symbol is decided without resync.
REQ-012 SHALL have port sym_err  output  1: one-cycle strobe on a mid-symbol sym_start.

Function
REQ-013 SHALL form product = sample_sig * carrier_sig as a 32-bit signed value, sign-extended to ACC_W before accumulation; no saturation or truncation.
REQ-014 SHALL implement states IDLE, INTEGRATE and DUMP, plus a sample counter 0..SAMPLES_PER_SYM.
REQ-015 In IDLE: sample_valid with sym_start -> acc = product, count = 1, go to INTEGRATE; sample_valid without sym_start is ignored.
REQ-016 In INTEGRATE: each sample_valid without sym_start -> acc += product, count += 1; the edge accepting sample number SAMPLES_PER_SYM -> go to DUMP.
REQ-017 In INTEGRATE: sample_valid with sym_start -> acc = product, count = 1, remain in INTEGRATE, pulse sym_err for one cycle, clear locked.
REQ-018 In DUMP (exactly one cycle): register bit_out = 1 if acc >= 0, otherwise 0 (a zero accumulator decides 1), and pulse bit_valid for one cycle.
REQ-019 DUMP SHALL then go to INTEGRATE and set locked.
REQ-020 A sample_valid during DUMP SHALL be accepted as sample 1 of the next symbol (acc = product, count = 1), whether or not sym_start is asserted, so continuous streaming loses no samples.
REQ-021 Latency: if the last sample of a symbol is accepted at edge N, bit_out and bit_valid update at edge N+1.
REQ-022 bit_valid and sym_err SHALL never be high for two consecutive cycles; sym_err SHALL not assert in IDLE or DUMP.
REQ-023 Cycles without sample_valid SHALL hold acc, count and state (except DUMP, which always exits after one cycle).

Reset
REQ-024 While reset_sig is high, independent of clk_sig: state = IDLE, acc = 0, count = 0, bit_out = 0, bit_valid = 0, locked = 0, sym_err = 0, and soft_out = 0 when present.
REQ-025 Reset asserted mid-symbol SHALL discard the partial accumulation and emit no decision; after release the block waits in IDLE for sym_start.

Configuration
REQ-026 Macro BPSK_DEMOD_SOFT_OUT_EN defined: the block SHALL add output port soft_out (16 bits, signed), loaded in DUMP with acc[ACC_W-1 -: 16] and held until the next DUMP.
REQ-027 Macro BPSK_DEMOD_SOFT_OUT_EN undefined: port soft_out and its register SHALL be absent; all other behaviour is identical.

Verification
REQ-028 Stimulus: SAMPLES_PER_SYM=256, sym_start on the first sample, sample = carrier = one full sine period (amplitude 16383). Response: bit_valid one cycle after the 256th sample, bit_out=1, locked=1.
REQ-029 Stimulus: as REQ-028 but with sample = negated carrier. Response: bit_out=0; soft_out negative when BPSK_DEMOD_SOFT_OUT_EN is defined.
REQ-030 Stimulus: 8 back-to-back symbols with pattern 10110010, sample_valid high every cycle, sym_start only on the first sample. Response: 8 bit_valid strobes spaced exactly 256 cycles apart carrying 10110010, with no gaps.
REQ-031 Stimulus: sym_start at sample 100 of a symbol. Response: sym_err pulses one cycle, locked=0, no bit_valid for the aborted symbol, next bit_valid 256 samples later.
REQ-032 Stimulus: reset_sig pulsed asynchronously at sample 128. Response: all outputs 0 immediately, no bit_valid, and samples ignored until the next sym_start.
REQ-033 Stimulus: sample = 0 for a whole symbol. Response: bit_out=1 (tie rule); random sample_valid gaps SHALL not change the decided value.

Source files
------------

// File: rtl/bpsk_demod.sv
// bpsk_demod -- coherent BPSK integrate-and-dump demodulator.
// Multiplies each qualified sample by the local reference carrier and integrates
// the product over SAMPLES_PER_SYM samples. The sign of the integral decides the
// bit, and a zero integral decides 1.
// Optional feature macro: BPSK_DEMOD_SOFT_OUT_EN adds the soft_out port. This port
// carries the top 16 bits of the integral at each decision.
// ACC_W must exceed 32 so that the full 32-bit product sign-extends without loss.
module bpsk_demod #(
   parameter int SAMPLES_PER_SYM = 256,
   parameter int ACC_W           = 40
) (
   input  logic               clk_sig,
   input  logic               reset_sig,
   input  logic signed [15:0] sample_sig,
   input  logic               sample_valid,
   input  logic signed [15:0] carrier_sig,
   input  logic               sym_start,
   output logic               bit_out,
   output logic               bit_valid,
   output logic               locked,
   output logic               sym_err
`ifdef BPSK_DEMOD_SOFT_OUT_EN
   ,
   output logic signed [15:0] soft_out
`endif
);

   localparam int CNT_W = $clog2(SAMPLES_PER_SYM + 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_SYM - 1);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_INTEGRATE = 2'd1,
      ST_DUMP      = 2'd2
   } state_t;

   state_t                    state_r;
   logic signed [ACC_W-1:0]   acc_r;
   logic        [CNT_W-1:0]   count_r;

   logic signed [31:0]        product_s;
   logic signed [ACC_W-1:0]   product_ext_s;
   logic signed [ACC_W-1:0]   acc_sum_s;
   logic        [CNT_W-1:0]   count_inc_s;

   // Hard decision: a non-negative integral (including exactly zero) is a 1.
   function automatic logic decide_bit(input logic signed [ACC_W-1:0] acc);
      return ~acc[ACC_W-1];
   endfunction

   // Full-precision correlator product and running sums; nothing saturates or truncates.
   always_comb begin
      product_s     = sample_sig * carrier_sig;
      product_ext_s = {{(ACC_W-32){product_s[31]}}, product_s};
      acc_sum_s     = acc_r + product_ext_s;
      count_inc_s   = count_r + CNT_ONE;
   end

   // Integrate-and-dump state machine with all outputs registered.
   always_ff @(posedge clk_sig or posedge reset_sig) begin
      if (reset_sig) begin
         state_r   <= ST_IDLE;
         acc_r     <= {ACC_W{1'b0}};
         count_r   <= CNT_ZERO;
         bit_out   <= 1'b0;
         bit_valid <= 1'b0;
         locked    <= 1'b0;
         sym_err   <= 1'b0;
`ifdef BPSK_DEMOD_SOFT_OUT_EN
         soft_out  <= 16'sd0;
`endif
      end else begin
         bit_valid <= 1'b0;
         sym_err   <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (sample_valid && sym_start) begin
                  acc_r   <= product_ext_s;
                  count_r <= CNT_ONE;
                  state_r <= ST_INTEGRATE;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_INTEGRATE: begin
               if (sample_valid) begin
                  if (sym_start && (count_r != CNT_ZERO)) begin
                     // Resync in mid-symbol: drop the partial integral and restart at sample 1.
                     // The strobe is suppressed on back-to-back resyncs so it never lasts two cycles.
                     acc_r   <= product_ext_s;
                     count_r <= CNT_ONE;
                     sym_err <= ~sym_err;
                     locked  <= 1'b0;
                  end else if (count_r == CNT_LAST) begin
                     acc_r   <= acc_sum_s;
                     count_r <= count_inc_s;
                     state_r <= ST_DUMP;
                  end else begin
                     // count_r == 0 only after a DUMP with no sample, where acc_r is already zero.
                     acc_r   <= acc_sum_s;
                     count_r <= count_inc_s;
                  end
               end else begin
                  state_r <= ST_INTEGRATE;
               end
            end
            ST_DUMP: begin
               bit_out   <= decide_bit(acc_r);
               bit_valid <= 1'b1;
               locked    <= 1'b1;
`ifdef BPSK_DEMOD_SOFT_OUT_EN
               soft_out  <= acc_r[ACC_W-1 -: 16];
`endif
               state_r   <= ST_INTEGRATE;
               if (sample_valid) begin
                  // A streaming sample in the dump cycle is sample 1 of the next symbol.
                  acc_r   <= product_ext_s;
                  count_r <= CNT_ONE;
               end else begin
                  acc_r   <= {ACC_W{1'b0}};
                  count_r <= CNT_ZERO;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               acc_r   <= {ACC_W{1'b0}};
               count_r <= CNT_ZERO;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bpsk_demod.sv
// tb_bpsk_demod -- directed self-checking bench for bpsk_demod (SAMPLES_PER_SYM = 256).
// Build with +define+BPSK_DEMOD_SOFT_OUT_EN to also check soft_out.
module tb_bpsk_demod;

   logic               clk_sig;
   logic               reset_sig;
   logic signed [15:0] sample_sig;
   logic               sample_valid;
   logic signed [15:0] carrier_sig;
   logic               sym_start;
   logic               bit_out;
   logic               bit_valid;
   logic               locked;
   logic               sym_err;
`ifdef BPSK_DEMOD_SOFT_OUT_EN
   logic signed [15:0] soft_out;
`endif

   bpsk_demod #(.SAMPLES_PER_SYM(256), .ACC_W(40)) dut (
      .clk_sig      (clk_sig),
      .reset_sig    (reset_sig),
      .sample_sig   (sample_sig),
      .sample_valid (sample_valid),
      .carrier_sig  (carrier_sig),
      .sym_start    (sym_start),
      .bit_out      (bit_out),
      .bit_valid    (bit_valid),
      .locked       (locked),
      .sym_err      (sym_err)
`ifdef BPSK_DEMOD_SOFT_OUT_EN
      ,
      .soft_out     (soft_out)
`endif
   );

   int tests_run   = 0;
   int tests_fail  = 0;
   int step_no     = 0;
   int strobe_cnt  = 0;
   int sym_err_cnt = 0;
   int consec_cnt  = 0;
   logic prev_bv   = 1'b0;
   logic prev_se   = 1'b0;
   int strobe_steps[$];
   logic strobe_bits[$];
   int sine_tab[256];

   // Free-running clock, period 10.
   initial clk_sig = 1'b0;
   always #5 clk_sig = ~clk_sig;

   // Run-time bound in case the bench stops advancing.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int got, input int exp);
      tests_run++;
      if (got !== exp) begin
         tests_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic signed [15:0] samp(input int kind, input int c);
      int v;
      case (kind)
         0:       v = c;
         1:       v = -c;
         2:       v = 0;
         3:       v = c >>> 6;
         default: v = 0;
      endcase
      return 16'(v);
   endfunction

   // One clock: drive on the falling edge, observe 1 time unit after the rising edge.
   task automatic step(input logic v, input logic signed [15:0] s,
                       input logic signed [15:0] c, input logic ss);
      @(negedge clk_sig);
      sample_valid = v;
      sample_sig   = s;
      carrier_sig  = c;
      sym_start    = ss;
      @(posedge clk_sig);
      #1;
      step_no++;
      if (bit_valid) begin
         strobe_cnt++;
         strobe_steps.push_back(step_no);
         strobe_bits.push_back(bit_out);
      end
      if (sym_err) sym_err_cnt++;
      if ((bit_valid && prev_bv) || (sym_err && prev_se)) consec_cnt++;
      prev_bv = bit_valid;
      prev_se = sym_err;
   endtask

   // One full symbol, with sym_start on sample 1 and optional random idle gaps,
   // followed by one idle cycle in which the decision must appear.
   task automatic run_symbol(input int kind, input int gap_max, input string tag,
                             input logic exp_bit);
      int s0;
      s0 = strobe_cnt;
      for (int i = 0; i < 256; i++) begin
         if (gap_max > 0) begin
            repeat ($urandom_range(0, gap_max)) step(1'b0, 16'sd0, 16'sd0, 1'b0);
         end
         step(1'b1, samp(kind, sine_tab[i]), 16'(sine_tab[i]), (i == 0));
      end
      check({tag, "_early"}, strobe_cnt - s0, 0);
      step(1'b0, 16'sd0, 16'sd0, 1'b0);
      check({tag, "_bv"},   int'(bit_valid), 1);
      check({tag, "_bit"},  int'(bit_out), int'(exp_bit));
      check({tag, "_lock"}, int'(locked), 1);
`ifdef BPSK_DEMOD_SOFT_OUT_EN
      if (kind == 0 || kind == 1) begin
         check({tag, "_soft_sign"}, int'(soft_out[15]), (kind == 1) ? 1 : 0);
      end
`endif
      step(1'b0, 16'sd0, 16'sd0, 1'b0);
      check({tag, "_bv_off"}, int'(bit_valid), 0);
   endtask

   initial begin
      int b;
      int s0;
      logic [7:0] pattern;
      pattern = 8'b10110010;

      for (int i = 0; i < 256; i++) begin
         sine_tab[i] = $rtoi(16383.0 * $sin(2.0 * 3.14159265358979 * i / 256.0));
      end

      reset_sig    = 1'b1;
      sample_valid = 1'b0;
      sample_sig   = 16'sd0;
      carrier_sig  = 16'sd0;
      sym_start    = 1'b0;
      #23;
      check("rst_bit_out",   int'(bit_out), 0);
      check("rst_bit_valid", int'(bit_valid), 0);
      check("rst_locked",    int'(locked), 0);
      check("rst_sym_err",   int'(sym_err), 0);
      @(negedge clk_sig);
      reset_sig = 1'b0;

      // In-phase sine symbol decides 1 and locks; anti-phase decides 0.
      run_symbol(0, 0, "pos", 1'b1);
      run_symbol(1, 0, "neg", 1'b0);

      // Eight back-to-back symbols, sym_start only on the very first sample.
      strobe_steps.delete();
      strobe_bits.delete();
      b = step_no;
      for (int k = 0; k < 2048; k++) begin
         step(1'b1, pattern[7 - k / 256] ? 16'(sine_tab[k % 256]) : 16'(-sine_tab[k % 256]),
              16'(sine_tab[k % 256]), (k == 0));
      end
      step(1'b0, 16'sd0, 16'sd0, 1'b0);
      check("stream_count", strobe_steps.size(), 8);
      if (strobe_steps.size() == 8) begin
         check("stream_first", strobe_steps[0] - b, 257);
         for (int j = 0; j < 8; j++) begin
            check($sformatf("stream_bit%0d", j), int'(strobe_bits[j]), int'(pattern[7 - j]));
            if (j > 0) check($sformatf("stream_gap%0d", j), strobe_steps[j] - strobe_steps[j - 1], 256);
         end
      end

      // Resync at sample 100: the large negative partial is discarded, and the
      // small positive restarted symbol decides 1 exactly 256 samples later.
      s0 = strobe_cnt;
      for (int i = 0; i < 99; i++) begin
         step(1'b1, samp(1, sine_tab[i]), 16'(sine_tab[i]), (i == 0));
      end
      step(1'b1, samp(3, sine_tab[0]), 16'(sine_tab[0]), 1'b1);
      check("resync_err",  int'(sym_err), 1);
      check("resync_lock", int'(locked), 0);
      for (int i = 1; i < 256; i++) begin
         step(1'b1, samp(3, sine_tab[i]), 16'(sine_tab[i]), 1'b0);
         if (i == 1) check("resync_err_off", int'(sym_err), 0);
      end
      check("resync_nostrobe", strobe_cnt - s0, 0);
      step(1'b0, 16'sd0, 16'sd0, 1'b0);
      check("resync_bv",   int'(bit_valid), 1);
      check("resync_bit",  int'(bit_out), 1);
      check("resync_lock2", int'(locked), 1);

      // Asynchronous reset at sample 128, applied between clock edges.
      for (int i = 0; i < 128; i++) begin
         step(1'b1, samp(0, sine_tab[i]), 16'(sine_tab[i]), (i == 0));
      end
      #2;
      reset_sig = 1'b1;
      #1;
      check("arst_bit_out", int'(bit_out), 0);
      check("arst_locked",  int'(locked), 0);
      check("arst_bv",      int'(bit_valid), 0);
      check("arst_err",     int'(sym_err), 0);
      @(posedge clk_sig);
      #2;
      reset_sig = 1'b0;
      s0 = strobe_cnt;
      for (int i = 0; i < 300; i++) begin
         step(1'b1, samp(0, sine_tab[i % 256]), 16'(sine_tab[i % 256]), 1'b0);
      end
      check("arst_ignored", strobe_cnt - s0, 0);
      check("arst_unlocked", int'(locked), 0);
      run_symbol(0, 0, "after_rst", 1'b1);

      // Tie rule and gap tolerance.
      run_symbol(1, 0, "pre_zero", 1'b0);
      run_symbol(2, 2, "zero_gaps", 1'b1);
      run_symbol(1, 3, "neg_gaps", 1'b0);

      check("sym_err_total", sym_err_cnt, 1);
      check("no_consecutive", consec_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
      $finish;
   end

endmodule
